ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Parametrised N-to-1 arbiter that shares one single-port RAM among `NUM_CH` compute-side requesters. It sits between the convolution accelerator's compute units and an SRAM macro. It adds features that a point-to-point compute/memory RAM link does not have:
- per-channel grant and read-valid handshakes
- round-robin fairness
- burst locking
- pipelined read-return routing for a RAM with configurable read latency

## Interface
Parameters:
- `NUM_CH`, 4: number of requesting channels (1..16).
- `ADDR_W`, 16: address width.
- `DATA_W`, 32: data width.
- `MEM_LAT`, 1: cycles from memory-side `cs`&`oe` sample to valid `mem_R_data` (1..4).

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ch_cs` in NUM_CH: per-channel request valid.
- `ch_oe` in NUM_CH: read request (when `ch_W_req`=0).
- `ch_W_req` in NUM_CH: write request; takes precedence over `ch_oe`.
- `ch_lock` in NUM_CH: hold grant for a burst.
- `ch_addr` in NUM_CH*ADDR_W: packed addresses; channel i is at bits [i*ADDR_W +: ADDR_W].
- `ch_W_data` in NUM_CH*DATA_W: packed write data.
- `ch_gnt` out NUM_CH: one-hot (or zero) accept strobe.
- `ch_R_valid` out NUM_CH: one-hot read-return strobe.
- `ch_R_data` out DATA_W: read data, broadcast to all channels; qualified by `ch_R_valid`.
- `mem_cs`, `mem_oe`, `mem_W_req` out 1: memory-side controls.
- `mem_addr` out ADDR_W, `mem_W_data` out DATA_W: memory-side address and write data.
- `mem_R_data` in DATA_W: memory read data.

## Operation
- Request semantics:
  - Channel i requests when `ch_cs[i]`=1.
  - The operation is a write if `ch_W_req[i]`=1, otherwise a read if `ch_oe[i]`=1.
  - `ch_cs`=1 with both `ch_oe` and `ch_W_req` at 0 is a no-op request. It is granted but issues `mem_cs`=0 and returns no data.
- Requesters hold cs/oe/W_req/addr/W_data stable until `ch_gnt[i]`=1 in the same cycle. At most one grant is issued per cycle.
- Arbitration states are IDLE and LOCKED:
  - IDLE:
    - Round-robin over requesting channels, starting at `last_gnt+1` (mod NUM_CH).
    - After reset `last_gnt`=NUM_CH-1, so channel 0 has top priority.
    - `last_gnt` updates on every grant.
    - If the granted channel has `ch_lock`=1, go to LOCKED with `owner`=i.
  - LOCKED:
    - Only `owner` can be granted. Other requests stall.
    - The owner is granted in every cycle it asserts `ch_cs`.
    - Return to IDLE in the cycle `ch_lock[owner]`=0. That cycle's arbitration is already round-robin, with `last_gnt`=owner.
- Issue: a granted request is registered into the memory-side outputs (`mem_cs`, `mem_oe`, `mem_W_req`, `mem_addr`, `mem_W_data`) on the next edge. In cycles with no grant, `mem_cs`/`mem_oe`/`mem_W_req` are 0, and `mem_addr`/`mem_W_data` hold their last value.
- Return routing:
  - Each issued read pushes {valid, channel id} into a MEM_LAT-deep shift pipe.
  - At the pipe output, `ch_R_valid[id]` pulses for one cycle and `ch_R_data`=`mem_R_data`, passed through combinationally.
  - Back-to-back reads from different channels return in issue order, one per cycle, with no bubbles.
- No backpressure on returns: a requester must accept `ch_R_valid` in any cycle.

## Timing
- Grant: combinational from `ch_cs`/`ch_lock`/state, in the same cycle as the request.
- Memory issue: 1 cycle after grant.
- Read data at requester: 1+MEM_LAT cycles after grant. With MEM_LAT=1, a grant in cycle t gives `ch_R_valid` in cycle t+2.
- Throughput: 1 access per cycle, sustained.
- Reset values:
  - `ch_gnt`=0, `ch_R_valid`=0.
  - `mem_cs`/`mem_oe`/`mem_W_req`=0, `mem_addr`=0, `mem_W_data`=0.
  - state=IDLE, `last_gnt`=NUM_CH-1, return pipe cleared.
- Reset mid-operation: in-flight reads are discarded, and no `ch_R_valid` is asserted in the cycles after `rst` is released until a new read is issued. While `rst`=1, `ch_gnt`=0.
- Simultaneous requests from all channels: each channel is granted exactly once per NUM_CH cycles, in order.
- NUM_CH=1: the grant equals `ch_cs[0]`, and lock has no observable effect beyond the state bit.
- A lock asserted by a non-granted channel is ignored.

## Structure
- Package `ram_arb_pkg` holds:
  - the `arb_state_e` enum (IDLE, LOCKED)
  - `MAX_CH`=16
  - the `ret_entry_t` struct {logic vld; logic [3:0] id}
- Sub-module `rr_arbiter`, parametrised on `NUM_CH`:
  - inputs: request vector, `last_gnt`, optional mask
  - output: one-hot grant vector
  - purely combinational
- The top module holds the lock FSM, the issue registers and the return pipe.

## Test plan
- Single read, MEM_LAT=1: ch2 reads addr 0x0010, RAM model holds 0xDEADBEEF → `ch_gnt[2]` in cycle t, `mem_addr`=0x0010 with `mem_oe`=1 in t+1, `ch_R_valid[2]`=1 with data 0xDEADBEEF in t+2.
- All 4 channels request continuously after reset → grant order 0,1,2,3,0,… with one grant per cycle and no gaps.
- Lock: ch1 holds `ch_lock` for 4 granted writes to 0x20..0x23 while ch0 and ch3 request → ch1 gets 4 consecutive grants, then ch3, then ch0.
- MEM_LAT=3, interleaved reads from ch0 and ch1 on consecutive cycles → `ch_R_valid` alternates 0,1,0,1, starting 4 cycles after the first grant, with matching data.
- Write-priority case: `ch_oe`=`ch_W_req`=1 on ch0 → `mem_W_req`=1, `mem_oe`=0, and no `ch_R_valid`.
- `rst` pulsed 1 cycle after a read grant → no `ch_R_valid` is ever asserted for that read, and all outputs are 0 in the cycle after reset.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the RAM port arbiter: arbitration state, return-pipe entry
// and a one-hot to channel-id helper.
package ram_arb_pkg;

  localparam int MAX_CH = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic       vld;
    logic [3:0] id;
  } ret_entry_t;

  function automatic logic [3:0] onehot_to_id(input logic [MAX_CH-1:0] oh);
    logic [3:0] id;
    id = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (oh[i]) id = 4'(i);
    end
    return id;
  endfunction

  // Distance of channel i after last in round-robin order (0 = next in line).
  function automatic int rr_dist(input int i, input int last, input int n);
    return (i - last - 1 + 2 * n) % n;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Compute-side request/grant/return bundle for the RAM port arbiter.
// master = requester side, slave = arbiter side.
interface ram_port_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [NUM_CH-1:0]        ch_cs;
  logic [NUM_CH-1:0]        ch_oe;
  logic [NUM_CH-1:0]        ch_W_req;
  logic [NUM_CH-1:0]        ch_lock;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*DATA_W-1:0] ch_W_data;
  logic [NUM_CH-1:0]        ch_gnt;
  logic [NUM_CH-1:0]        ch_R_valid;
  logic [DATA_W-1:0]        ch_R_data;

  modport master (
    output ch_cs, ch_oe, ch_W_req, ch_lock, ch_addr, ch_W_data,
    input  ch_gnt, ch_R_valid, ch_R_data
  );

  modport slave (
    input  ch_cs, ch_oe, ch_W_req, ch_lock, ch_addr, ch_W_data,
    output ch_gnt, ch_R_valid, ch_R_data
  );
endinterface

// File: rtl/ram_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: grants the masked requester closest after last_gnt.
// Zero latency; no backpressure (pure function of its inputs).
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [3:0]        last_gnt,
  input  logic [NUM_CH-1:0] mask,
  output logic [NUM_CH-1:0] gnt
);

  int best_d;

  always_comb begin
    gnt    = '0;
    best_d = NUM_CH;
    for (int i = 0; i < NUM_CH; i++) begin
      if (req[i] && mask[i] && (rr_dist(i, int'(last_gnt), NUM_CH) < best_d)) begin
        best_d = rr_dist(i, int'(last_gnt), NUM_CH);
        gnt    = '0;
        gnt[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM among NUM_CH requesters: grant same cycle, issue +1, read data +1+MEM_LAT.
// Stalled requesters hold their request; read returns cannot be backpressured.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  ram_port_arbiter_if.slave ch,
  output logic              mem_cs,
  output logic              mem_oe,
  output logic              mem_W_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_W_data,
  input  logic [DATA_W-1:0] mem_R_data
);

  arb_state_e        state_q, state_d;
  logic [NUM_CH-1:0] owner_q, owner_d;
  logic [3:0]        last_q, last_d;
  logic [NUM_CH-1:0] rr_mask, rr_gnt, gnt;
  logic              lock_held, gnt_any, gnt_wr, gnt_rd, gnt_lock;
  logic [3:0]        gnt_id;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_wdata;
  logic [3:0]        mem_id_q;
  ret_entry_t        ret_q [MEM_LAT];

  // While the owner keeps its lock, only the owner may win; owner is kept one-hot.
  assign lock_held = (state_q == LOCKED) && (|(ch.ch_lock & owner_q));
  assign rr_mask   = lock_held ? owner_q : '1;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .req      (ch.ch_cs),
    .last_gnt (last_q),
    .mask     (rr_mask),
    .gnt      (rr_gnt)
  );

  assign gnt        = rst ? '0 : rr_gnt;
  assign ch.ch_gnt  = gnt;
  assign gnt_any    = |gnt;
  assign gnt_wr     = |(gnt & ch.ch_W_req);
  assign gnt_rd     = (|(gnt & ch.ch_oe)) & ~gnt_wr;
  assign gnt_lock   = |(gnt & ch.ch_lock);
  assign gnt_id     = onehot_to_id(MAX_CH'(gnt));

  always_comb begin
    gnt_addr  = '0;
    gnt_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        gnt_addr  = ch.ch_addr[i*ADDR_W +: ADDR_W];
        gnt_wdata = ch.ch_W_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    if (gnt_any) begin
      last_d = gnt_id;
      if (gnt_lock) begin
        state_d = LOCKED;
        owner_d = gnt;
      end else begin
        state_d = IDLE;
      end
    end else if (state_q == LOCKED && !lock_held) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      last_q     <= 4'(NUM_CH - 1);
      mem_cs     <= 1'b0;
      mem_oe     <= 1'b0;
      mem_W_req  <= 1'b0;
      mem_addr   <= '0;
      mem_W_data <= '0;
      mem_id_q   <= '0;
      for (int s = 0; s < MEM_LAT; s++) ret_q[s] <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      mem_cs    <= gnt_wr | gnt_rd;
      mem_oe    <= gnt_rd;
      mem_W_req <= gnt_wr;
      if (gnt_any) begin
        mem_addr   <= gnt_addr;
        mem_W_data <= gnt_wdata;
        mem_id_q   <= gnt_id;
      end
      // Entry enters when the RAM samples the read; exits when its data is valid.
      ret_q[0] <= '{vld: mem_cs & mem_oe, id: mem_id_q};
      for (int s = 1; s < MEM_LAT; s++) ret_q[s] <= ret_q[s-1];
    end
  end

  assign ch.ch_R_valid = ret_q[MEM_LAT-1].vld ? (NUM_CH'(1) << ret_q[MEM_LAT-1].id) : '0;
  assign ch.ch_R_data  = mem_R_data;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: two instances (MEM_LAT 1 and 3) share stimulus and are
// compared every cycle against a rule-level model, plus directed literal checks.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cs, oe, wr, lk;
  logic [15:0] a_ch [4];
  logic [31:0] w_ch [4];
  logic [3:0]  g;

  logic        m_cs [2], m_oe [2], m_wr [2];
  logic [15:0] m_addr [2];
  logic [31:0] m_wd [2], m_rd [2];
  logic [3:0]  gnt_o [2], rv_o [2];
  logic [31:0] rd_o [2];

  int n_chk = 0, n_pass = 0, nc = 0;
  int LAT [2] = '{1, 3};

  always #5 clk = ~clk;

  ram_port_arbiter_if #(.NUM_CH(4), .ADDR_W(16), .DATA_W(32)) if0 ();
  ram_port_arbiter_if #(.NUM_CH(4), .ADDR_W(16), .DATA_W(32)) if1 ();

  assign if0.ch_cs = cs;    assign if1.ch_cs = cs;
  assign if0.ch_oe = oe;    assign if1.ch_oe = oe;
  assign if0.ch_W_req = wr; assign if1.ch_W_req = wr;
  assign if0.ch_lock = lk;  assign if1.ch_lock = lk;
  assign if0.ch_addr = {a_ch[3], a_ch[2], a_ch[1], a_ch[0]};
  assign if1.ch_addr = {a_ch[3], a_ch[2], a_ch[1], a_ch[0]};
  assign if0.ch_W_data = {w_ch[3], w_ch[2], w_ch[1], w_ch[0]};
  assign if1.ch_W_data = {w_ch[3], w_ch[2], w_ch[1], w_ch[0]};
  assign gnt_o[0] = if0.ch_gnt;  assign gnt_o[1] = if1.ch_gnt;
  assign rv_o[0] = if0.ch_R_valid; assign rv_o[1] = if1.ch_R_valid;
  assign rd_o[0] = if0.ch_R_data;  assign rd_o[1] = if1.ch_R_data;

  ram_port_arbiter #(.NUM_CH(4), .ADDR_W(16), .DATA_W(32), .MEM_LAT(1)) dut0 (
    .clk(clk), .rst(rst), .ch(if0.slave),
    .mem_cs(m_cs[0]), .mem_oe(m_oe[0]), .mem_W_req(m_wr[0]),
    .mem_addr(m_addr[0]), .mem_W_data(m_wd[0]), .mem_R_data(m_rd[0])
  );

  ram_port_arbiter #(.NUM_CH(4), .ADDR_W(16), .DATA_W(32), .MEM_LAT(3)) dut1 (
    .clk(clk), .rst(rst), .ch(if1.slave),
    .mem_cs(m_cs[1]), .mem_oe(m_oe[1]), .mem_W_req(m_wr[1]),
    .mem_addr(m_addr[1]), .mem_W_data(m_wd[1]), .mem_R_data(m_rd[1])
  );

  function automatic logic [31:0] init_val(input int a);
    return 32'h1000_0000 ^ (32'(a) * 32'h0101_0101);
  endfunction

  // RAM macros: write on cs&W_req, read data valid MEM_LAT cycles after the sample, junk otherwise.
  logic [31:0] ram [2][256];
  logic [31:0] rpipe [2][4];
  bit ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int d = 0; d < 2; d++)
        for (int a = 0; a < 256; a++) ram[d][a] <= init_val(a);
      ram_init <= 1'b1;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (m_cs[d] && m_wr[d]) ram[d][m_addr[d][7:0]] <= m_wd[d];
        for (int s = 3; s > 0; s--) rpipe[d][s] <= rpipe[d][s-1];
        rpipe[d][0] <= (m_cs[d] && m_oe[d]) ? ram[d][m_addr[d][7:0]] : (32'hBAD0_0000 ^ 32'(nc));
      end
    end
  end
  assign m_rd[0] = rpipe[0][0];
  assign m_rd[1] = rpipe[1][2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, nc);
  endtask

  // ---------------- reference model ----------------
  bit          armed = 1'b0;
  int          m_last, m_owner;
  bit          m_locked;
  logic        e_cs, e_oe, e_wr;
  logic [15:0] e_addr;
  logic [31:0] e_wd;
  int          e_rv [2][8];
  logic [31:0] e_rd [2][8];
  logic [31:0] shadow [256];

  task automatic model_reset();
    m_last = 3; m_owner = 0; m_locked = 1'b0;
    e_cs = 1'b0; e_oe = 1'b0; e_wr = 1'b0; e_addr = '0; e_wd = '0;
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 8; s++) e_rv[d][s] = -1;
  endtask

  function automatic int model_grant();
    if (m_locked && lk[m_owner]) return cs[m_owner] ? m_owner : -1;
    for (int k = 1; k <= 4; k++)
      if (cs[(m_last + k) % 4]) return (m_last + k) % 4;
    return -1;
  endfunction

  task automatic model_step(input int gi);
    int a;
    if (gi < 0) begin
      e_cs = 1'b0; e_oe = 1'b0; e_wr = 1'b0;
      if (m_locked && !lk[m_owner]) m_locked = 1'b0;
    end else begin
      m_last = gi; m_owner = gi; m_locked = lk[gi];
      a = int'(a_ch[gi][7:0]);
      e_wr = wr[gi]; e_oe = !wr[gi] && oe[gi]; e_cs = wr[gi] || oe[gi];
      e_addr = a_ch[gi]; e_wd = w_ch[gi];
      if (wr[gi]) shadow[a] = w_ch[gi];
      else if (oe[gi])
        for (int d = 0; d < 2; d++) begin
          e_rv[d][(nc + 1 + LAT[d]) % 8] = gi;
          e_rd[d][(nc + 1 + LAT[d]) % 8] = shadow[a];
        end
    end
  endtask

  always @(negedge clk) begin
    int eg, s;
    if (!armed) begin
      if (rst) begin
        for (int a = 0; a < 256; a++) shadow[a] = init_val(a);
        model_reset();
        armed = 1'b1;
      end
    end else begin
      eg = rst ? -1 : model_grant();
      s  = nc % 8;
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("mem_cs[%0d]", d), m_cs[d], e_cs);
        chk($sformatf("mem_oe[%0d]", d), m_oe[d], e_oe);
        chk($sformatf("mem_W_req[%0d]", d), m_wr[d], e_wr);
        chk($sformatf("mem_addr[%0d]", d), m_addr[d], e_addr);
        chk($sformatf("mem_W_data[%0d]", d), m_wd[d], e_wd);
        chk($sformatf("ch_gnt[%0d]", d), gnt_o[d], (eg < 0) ? 64'd0 : (64'd1 << eg));
        if (e_rv[d][s] >= 0) begin
          chk($sformatf("ch_R_valid[%0d]", d), rv_o[d], 64'd1 << e_rv[d][s]);
          chk($sformatf("ch_R_data[%0d]", d), rd_o[d], e_rd[d][s]);
        end else begin
          chk($sformatf("ch_R_valid[%0d]", d), rv_o[d], 64'd0);
        end
        e_rv[d][s] = -1;
      end
      if (rst) model_reset();
      else model_step(eg);
    end
    nc++;
  end

  // ---------------- stimulus ----------------
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit c, input bit o, input bit w, input bit l,
                         input logic [15:0] a, input logic [31:0] wd);
    cs[i] = c; oe[i] = o; wr[i] = w; lk[i] = l; a_ch[i] = a; w_ch[i] = wd;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_all();
    next();
    rst = 1'b0;
  endtask

  task automatic rand_req(input int i);
    int r;
    r = $urandom_range(0, 7);
    set_req(i, 1'b1, (r >= 3 && r < 7) || r == 0, r < 3, $urandom_range(0, 3) == 0,
            16'($urandom_range(0, 15)), $urandom);
  endtask

  initial begin
    rst = 1'b1;
    clear_all();
    repeat (3) next();
    @(negedge clk);
    chk("reset_gnt", gnt_o[0], 4'b0000);
    chk("reset_mem_cs", m_cs[0], 1'b0);
    chk("reset_mem_addr", m_addr[0], 16'h0000);
    chk("reset_rvalid", rv_o[1], 4'b0000);
    next();
    rst = 1'b0;

    // Single read from ch2 after ch0 stores 0xDEADBEEF at 0x10.
    set_req(0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 32'hDEADBEEF);
    next(); clear_all();
    next();
    set_req(2, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0010, 32'h0);
    @(negedge clk); chk("single_gnt", gnt_o[0], 4'b0100);
    next(); clear_all();
    @(negedge clk); chk("single_mem_addr", m_addr[0], 16'h0010); chk("single_mem_oe", m_oe[0], 1'b1);
    next();
    @(negedge clk); chk("single_rvalid", rv_o[0], 4'b0100); chk("single_rdata", rd_o[0], 32'hDEADBEEF);
    next();

    // All channels requesting continuously from reset.
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b1, 1'b0, 1'b0, 16'(i), 32'h0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); chk("rr_order", gnt_o[0], 64'd1 << (k % 4));
      next();
    end

    // ch1 burst-locks four writes while ch0 and ch3 wait.
    do_reset();
    set_req(0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0030, 32'h0);
    @(negedge clk); chk("lock_pre_gnt", gnt_o[0], 4'b0001);
    next();
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0031, 32'h0);
      set_req(3, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0033, 32'h0);
      set_req(1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0020 + 16'(k), 32'hA000 + 32'(k));
      @(negedge clk); chk("lock_gnt", gnt_o[0], 4'b0010);
      next();
    end
    set_req(1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    @(negedge clk); chk("unlock_gnt3", gnt_o[0], 4'b1000);
    chk("lock_last_wr", m_wr[0], 1'b1); chk("lock_last_addr", m_addr[0], 16'h0023);
    next();
    set_req(3, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    @(negedge clk); chk("unlock_gnt0", gnt_o[0], 4'b0001);
    next(); clear_all();
    repeat (6) next();

    // Interleaved reads ch0/ch1 on the MEM_LAT=3 instance.
    for (int k = 0; k < 8; k++) begin
      clear_all();
      if (k < 4) set_req(k % 2, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0040 + 16'(k), 32'h0);
      @(negedge clk);
      if (k >= 4) chk("ml3_rvalid", rv_o[1], (k % 2 == 0) ? 64'd1 : 64'd2);
      else chk("ml3_quiet", rv_o[1], 4'b0000);
      next();
    end
    repeat (4) next();

    // Write takes precedence over read on the same request.
    set_req(0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0050, 32'h5555AAAA);
    next(); clear_all();
    @(negedge clk); chk("wprio_wr", m_wr[0], 1'b1); chk("wprio_oe", m_oe[0], 1'b0);
    next();
    @(negedge clk); chk("wprio_no_rvalid", rv_o[0], 4'b0000);
    next();

    // Reset one cycle after a read grant discards the read.
    set_req(1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0010, 32'h0);
    @(negedge clk); chk("rst_rd_gnt", gnt_o[0], 4'b0010);
    next(); clear_all(); rst = 1'b1;
    next(); rst = 1'b0;
    @(negedge clk);
    chk("post_rst_gnt", gnt_o[0], 4'b0000); chk("post_rst_cs", m_cs[0], 1'b0);
    chk("post_rst_addr", m_addr[0], 16'h0000); chk("post_rst_wdata", m_wd[0], 32'h0);
    for (int k = 0; k < 5; k++) begin
      chk("post_rst_rvalid", {rv_o[1], rv_o[0]}, 8'h00);
      next();
      @(negedge clk);
    end
    next();

    // Randomised traffic with held requests, random locks, no-ops and occasional resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      g = gnt_o[0];
      next();
      rst = (!rst && $urandom_range(0, 299) == 0);
      for (int i = 0; i < 4; i++) begin
        if (g[i] || !cs[i]) begin
          if ($urandom_range(0, 2) != 0) rand_req(i);
          else set_req(i, 1'b0, 1'b0, 1'b0, 1'b0, a_ch[i], w_ch[i]);
        end
      end
    end
    rst = 1'b0;
    clear_all();
    repeat (8) next();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
